uart_tx_arbiter: RTL and testbench

Shares one uart_tx transmitter between NUM_REQ word sources using round-robin arbitration.
Each requester presents a word with a valid/ack handshake. The arbiter latches the winning word, drives the transmitter's data/can_send_next_word/ready handshake, and waits for the frame to finish before re-arbitrating.
It sits between the packet producers (debug streams, status reporters) and the uart_tx instance.

---
 rtl/uart_tx_arb_pkg.sv | 49 ++++
 rtl/uart_tx_arbiter_rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared types and helpers for the uart_tx round-robin arbiter.
//   arb_state_e : sequencing states of the arbiter (ARB, ISSUE, BUSY)
//   rr_pick_t   : result of a round-robin search (any valid + winner index)
//   rr_pick()   : round-robin winner search over a valid vector, starting
//                 just above the last-served pointer and wrapping
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    // Widest supported requester count; the search is written for this size
    // and narrower instances zero-extend into it.
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             any;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index searching ptr+1, ptr+2, ... modulo num_req.
    // The pointer itself is visited last, so the last-served requester
    // only wins again when nobody else is asking.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 num_req);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((k <= num_req) && !res.any && valid[cand[IDX_W-1:0]]) begin
                res.any = 1'b1;
                res.idx = cand[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker.
//   valid     in  NUM_REQ  candidate requesters
//   ptr       in  ID_W     index served last (search starts at ptr+1)
//   winner    out ID_W     chosen index (don't-care when any_valid=0)
//   any_valid out 1        at least one candidate is valid
// -----------------------------------------------------------------------------
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    rr_pick_t           pick;
    logic [MAX_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]   ptr_ext;

    // NOTE: every signal assigned in always_comb gets a value on every path
    //       (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        valid_ext = MAX_REQ'(valid);
        ptr_ext   = IDX_W'(ptr);
        pick      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
        winner    = ID_W'(pick.idx);
        any_valid = pick.any;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ word sources with round-robin
// arbitration. A winning word is latched, offered to the transmitter with
// tx_send until the transmitter drops tx_ready (word accepted), and the
// arbiter then waits for tx_ready to return before arbitrating again.
//
// Ports:
//   clock, resetn         clock, asynchronous active-low reset
//   req_valid [NUM_REQ]   requester i has a word pending
//   req_data  [NUM_REQ*W] word of requester i at [i*WIDTH +: WIDTH]
//   req_last  [NUM_REQ]   last word of a packet (packet-lock build only)
//   req_ack   [NUM_REQ]   one-cycle pulse: word of requester i taken
//   tx_data   [WIDTH]     to uart_tx data
//   tx_send               to uart_tx can_send_next_word
//   tx_ready              from uart_tx ready
//   grant_id  [ID_W]      requester currently or last served
//   busy                  high whenever the arbiter is not in ARB
//
// Build option:
//   UART_TX_ARB_PACKET_LOCK_EN  when defined, a requester that is granted a
//   word with req_last=0 keeps the grant until its req_last=1 word is taken.
//   When undefined, req_last is ignored and every word is arbitrated alone.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_send,
    input  logic                     tx_ready,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    arb_state_e         state_q, state_d;
    logic [WIDTH-1:0]   tx_data_q, tx_data_d;
    logic               tx_send_q, tx_send_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] cand_valid;
    logic [ID_W-1:0]    winner;
    logic               any_valid;
    logic               grant_fire;
    logic [WIDTH-1:0]   winner_data;

    // Acceptance is only ever looked for in ISSUE, so a tx_ready dip while
    // sitting in ARB just blocks the grant for that cycle.
    assign grant_fire = (state_q == ST_ARB) && tx_ready && any_valid;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
    logic lock_q, lock_d;
    logic winner_last;

    // While locked only the current owner may be picked. The pointer equals
    // grant_id here, so the search reaches the owner after a full wrap.
    assign cand_valid = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id_q))
                               : req_valid;

    always_comb begin
        winner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                winner_last = req_last[i];
            end
        end
    end

    // Each granted word re-decides the lock: a non-last word holds it,
    // the last word of the packet releases it.
    always_comb begin
        lock_d = lock_q;
        if (grant_fire) begin
            lock_d = !winner_last;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_req_last;

    assign cand_valid      = req_valid;
    assign unused_req_last = ^req_last;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .valid     (cand_valid),
        .ptr       (ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Constant-slice mux keeps the part-select width obvious to lint.
    always_comb begin
        winner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                winner_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = tx_send_q;
        req_ack_d  = '0;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;

        unique case (state_q)
            ST_ARB: begin
                tx_send_d = 1'b0;
                if (grant_fire) begin
                    tx_data_d         = winner_data;
                    tx_send_d         = 1'b1;
                    req_ack_d[winner] = 1'b1;
                    grant_id_d        = winner;
                    ptr_d             = winner;
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // tx_ready falling is the transmitter latching our word;
                // no timeout, it may be finishing a previous stop bit.
                if (!tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tx_ready) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = ST_ARB;
            end
        endcase

        busy_d = (state_d != ST_ARB);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    //       samples the pre-edge values, independent of statement order.
    // NOTE: every flop here is control or output state and gets a defined
    //       reset value; a mid-frame reset simply abandons the word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_ARB;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            req_ack_q  <= '0;
            grant_id_q <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            req_ack_q  <= req_ack_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_send  = tx_send_q;
    assign req_ack  = req_ack_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter with a behavioural uart_tx model (ticks_per_bit
// = TPB, 10-bit frame, ready high while idle and during the stop bit, a word
// offered during the stop bit is taken at its end). Per-requester word
// queues drive the request side; frames latched by the model are checked
// against an expected-frame queue filled when stimulus is loaded.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int TPB     = 4;
    localparam int BUDGET  = 400;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } frame_t;

    logic                     clock = 1'b0;
    logic                     resetn = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_last = '0;
    logic [NUM_REQ-1:0]       req_ack;
    logic [WIDTH-1:0]         tx_data;
    logic                     tx_send;
    logic                     tx_ready;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // ---------------- uart_tx model ----------------
    logic   m_active;
    int     m_bit;
    int     m_tick;
    frame_t exp_q[$];
    frame_t cap_q[$];

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            tx_ready <= 1'b1;
            m_bit    <= 0;
            m_tick   <= 0;
        end else if (!m_active) begin
            if (tx_send) begin
                cap_q.push_back('{id: grant_id, data: tx_data});
                m_active <= 1'b1;
                m_bit    <= 0;
                m_tick   <= 0;
                tx_ready <= 1'b0;
            end
        end else if (m_tick != TPB - 1) begin
            m_tick <= m_tick + 1;
        end else begin
            m_tick <= 0;
            if (m_bit == 9) begin
                if (tx_send) begin
                    cap_q.push_back('{id: grant_id, data: tx_data});
                    m_bit    <= 0;
                    tx_ready <= 1'b0;
                end else begin
                    m_active <= 1'b0;
                end
            end else begin
                m_bit <= m_bit + 1;
                if (m_bit == 8) tx_ready <= 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    int               ack_cnt [NUM_REQ];
    int               multi_ack = 0;
    int               stab_err = 0;
    int               send_hi = 0;
    logic             prev_send = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clock) begin
        if ($countones(req_ack) > 1) multi_ack++;
        for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) ack_cnt[i]++;
        if (tx_send) send_hi++;
        if (tx_send && prev_send && (tx_data !== prev_data)) stab_err++;
        prev_send = tx_send;
        prev_data = tx_data;
    end

    // ---------------- requester side ----------------
    logic [WIDTH:0] rq [NUM_REQ][$];

    task automatic refresh();
        logic [WIDTH:0] w;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                w = rq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = w[WIDTH-1:0];
                req_last[i] = w[WIDTH];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic load_word(input int i, input logic last, input logic [WIDTH-1:0] data);
        rq[i].push_back({last, data});
        refresh();
    endtask

    task automatic clear_requests();
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        refresh();
    endtask

    // An acked word is retired and the next one presented in the following cycle.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (resetn) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ack[i] && (rq[i].size() > 0)) void'(rq[i].pop_front());
            end
            refresh();
        end
    end

    // ---------------- helpers (waiting only) ----------------
    task automatic apply_reset();
        resetn = 1'b0;
        clear_requests();
        exp_q.delete();
        cap_q.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_frames(input int n, input string name);
        int cyc = 0;
        while ((cap_q.size() < n) && (cyc < BUDGET * n)) begin
            @(negedge clock);
            cyc++;
        end
        if (cap_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d frames, required %0d", name, cap_q.size(), n);
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((m_active || busy) && (cyc < BUDGET)) begin
            @(negedge clock);
            cyc++;
        end
        if (m_active || busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%b model_active=%b, required both 0", name, busy, m_active);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        clear_requests();
        @(negedge clock);
        n_cmp++; if (tx_send !== 1'b0) begin n_bad++; $display("FAIL reset_tx_send: got %b, required 0", tx_send); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        n_cmp++; if (req_ack !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ack: got %b, required 0000", req_ack); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        int base = ack_cnt[0];
        frame_t e, c;
        exp_q.push_back('{id: 2'd0, data: 8'hA5});
        @(posedge clock); #1;
        load_word(0, 1'b1, 8'hA5);
        @(posedge clock); #1;
        n_cmp++; if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack_latency: got %b, required 0001", req_ack); end
        n_cmp++; if (tx_send !== 1'b1) begin n_bad++; $display("FAIL single_tx_send: got %b, required 1", tx_send); end
        n_cmp++; if (tx_data !== 8'hA5) begin n_bad++; $display("FAIL single_tx_data: got %h, required a5", tx_data); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_high: got %b, required 1", busy); end
        @(posedge clock); #1;
        n_cmp++; if (req_ack !== 4'b0000) begin n_bad++; $display("FAIL single_ack_pulse: got %b, required 0000", req_ack); end
        wait_frames(1, "single");
        wait_idle("single");
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_low: got %b, required 0", busy); end
        n_cmp++; if (ack_cnt[0] - base !== 1) begin n_bad++; $display("FAIL single_ack_count: got %0d, required 1", ack_cnt[0] - base); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL single_grant_id: got %0d, required 0", grant_id); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL single_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL single_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    task automatic test_fairness();
        int base [NUM_REQ];
        int base_multi;
        frame_t e, c;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) base[i] = ack_cnt[i];
        base_multi = multi_ack;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                exp_q.push_back('{id: ID_W'(i), data: WIDTH'(8'h10 + i)});
        for (int i = 0; i < NUM_REQ; i++) begin
            load_word(i, 1'b1, WIDTH'(8'h10 + i));
            load_word(i, 1'b1, WIDTH'(8'h10 + i));
        end
        wait_frames(8, "fair");
        wait_idle("fair");
        for (int i = 0; i < NUM_REQ; i++) begin
            n_cmp++;
            if (ack_cnt[i] - base[i] !== 2) begin n_bad++; $display("FAIL fair_ack_count_%0d: got %0d, required 2", i, ack_cnt[i] - base[i]); end
        end
        n_cmp++; if (multi_ack !== base_multi) begin n_bad++; $display("FAIL fair_onehot_ack: got %0d multi-bit cycles, required 0", multi_ack - base_multi); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL fair_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL fair_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    task automatic test_wrap_sparse();
        frame_t e, c;
        apply_reset();
        exp_q.push_back('{id: 2'd1, data: 8'h21});
        exp_q.push_back('{id: 2'd3, data: 8'h31});
        exp_q.push_back('{id: 2'd1, data: 8'h22});
        load_word(1, 1'b1, 8'h21);
        load_word(1, 1'b1, 8'h22);
        load_word(3, 1'b1, 8'h31);
        wait_frames(3, "wrap");
        wait_idle("wrap");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL wrap_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL wrap_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    task automatic test_late_accept();
        int cyc = 0;
        int base_ack, base_stab, base_hi, hi;
        frame_t e, c;
        apply_reset();
        exp_q.push_back('{id: 2'd0, data: 8'h40});
        exp_q.push_back('{id: 2'd2, data: 8'h42});
        load_word(0, 1'b1, 8'h40);
        while (!(m_active && (m_bit == 9)) && (cyc < BUDGET)) begin
            @(posedge clock); #1;
            cyc++;
        end
        n_cmp++;
        if (!(m_active && (m_bit == 9))) begin n_bad++; $display("FAIL late_stop_bit_timeout: bit %0d, required 9", m_bit); end
        base_ack  = ack_cnt[2];
        base_stab = stab_err;
        base_hi   = send_hi;
        load_word(2, 1'b1, 8'h42);
        wait_frames(2, "late");
        wait_idle("late");
        hi = send_hi - base_hi;
        n_cmp++; if (stab_err !== base_stab) begin n_bad++; $display("FAIL late_hold_stable: got %0d changes, required 0", stab_err - base_stab); end
        n_cmp++; if ((hi < 2) || (hi > TPB + 1)) begin n_bad++; $display("FAIL late_send_hold: got %0d cycles, required 2..%0d", hi, TPB + 1); end
        n_cmp++; if (ack_cnt[2] - base_ack !== 1) begin n_bad++; $display("FAIL late_ack_count: got %0d, required 1", ack_cnt[2] - base_ack); end
        n_cmp++; if (cap_q.size() !== 2) begin n_bad++; $display("FAIL late_frame_count: got %0d, required 2", cap_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL late_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL late_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        frame_t e, c;
        apply_reset();
        load_word(1, 1'b1, 8'h71);
        while (!tx_send && (cyc < BUDGET)) begin @(posedge clock); #1; cyc++; end
        resetn = 1'b0;
        #1;
        n_cmp++; if (tx_send !== 1'b0) begin n_bad++; $display("FAIL rst_issue_tx_send: got %b, required 0", tx_send); end
        n_cmp++; if (req_ack !== 4'b0000) begin n_bad++; $display("FAIL rst_issue_req_ack: got %b, required 0000", req_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_issue_busy: got %b, required 0", busy); end
        clear_requests();
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        load_word(2, 1'b1, 8'h72);
        cyc = 0;
        while (!(busy && !tx_send && m_active) && (cyc < BUDGET)) begin @(posedge clock); #1; cyc++; end
        resetn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_busy: got %b, required 0", busy); end
        n_cmp++; if (tx_send !== 1'b0) begin n_bad++; $display("FAIL rst_busy_tx_send: got %b, required 0", tx_send); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_busy_grant_id: got %0d, required 0", grant_id); end
        clear_requests();
        @(negedge clock);
        cap_q.delete();
        exp_q.delete();
        resetn = 1'b1;
        @(negedge clock);
        exp_q.push_back('{id: 2'd0, data: 8'h70});
        exp_q.push_back('{id: 2'd3, data: 8'h73});
        load_word(3, 1'b1, 8'h73);
        load_word(0, 1'b1, 8'h70);
        wait_frames(2, "rst");
        wait_idle("rst");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL rst_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL rst_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    task automatic test_packet();
        int cyc = 0;
        int base = ack_cnt[2];
        frame_t e, c;
        apply_reset();
        base = ack_cnt[2];
`ifdef UART_TX_ARB_PACKET_LOCK_EN
        exp_q.push_back('{id: 2'd2, data: 8'h50});
        exp_q.push_back('{id: 2'd2, data: 8'h51});
        exp_q.push_back('{id: 2'd2, data: 8'h52});
        exp_q.push_back('{id: 2'd0, data: 8'h60});
        exp_q.push_back('{id: 2'd1, data: 8'h61});
`else
        exp_q.push_back('{id: 2'd2, data: 8'h50});
        exp_q.push_back('{id: 2'd0, data: 8'h60});
        exp_q.push_back('{id: 2'd1, data: 8'h61});
        exp_q.push_back('{id: 2'd2, data: 8'h51});
        exp_q.push_back('{id: 2'd2, data: 8'h52});
`endif
        load_word(2, 1'b0, 8'h50);
        load_word(2, 1'b0, 8'h51);
        load_word(2, 1'b1, 8'h52);
        while ((ack_cnt[2] == base) && (cyc < BUDGET)) begin @(negedge clock); cyc++; end
        load_word(0, 1'b1, 8'h60);
        load_word(1, 1'b1, 8'h61);
        wait_frames(5, "pkt");
        wait_idle("pkt");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (cap_q.size() == 0) begin n_bad++; $display("FAIL pkt_frame: no frame, required id %0d data %h", e.id, e.data); end
            else begin
                c = cap_q.pop_front();
                if (c !== e) begin n_bad++; $display("FAIL pkt_frame: got id %0d data %h, required id %0d data %h", c.id, c.data, e.id, e.data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap_sparse();
        test_late_accept();
        test_reset_mid();
        test_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
